fm_modulator: RTL and testbench

//  Transmit-side counterpart of the FM demodulator. Produces a signed 8-bit FM carrier from a signed
//  8-bit baseband sample stream. Carrier centre is set by ctr_ctrl, the same frequency-control word
//  the demodulator's NCO uses. Deviation is per-sample ctr_ctrl + sample*dev_ctrl, fed to a
//  32-bit phase accumulator that drives a 256-entry sine LUT.

---
 rtl/fm_modulator_if.sv | 32 +++
 rtl/fm_modulator.sv | 115 +++++++++++
 tb/tb_fm_modulator.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fm_modulator_if.sv
`default_nettype none
// ============================================================================
//  Module      : fm_modulator_if
//  Description : Baseband-in / carrier-out bundle for fm_modulator.
//                master : the baseband source driving samples and control words
//                slave  : the modulator consuming them and producing the carrier
//  Signals     : enable, sample_valid, sample[7:0], ctr_ctrl[31:0],
//                dev_ctrl[15:0] (master -> slave)
//                modulated[7:0], mod_valid, wrap (slave -> master)
//  Revision    : 1.0  initial release
// ============================================================================
interface fm_modulator_if;
    logic        enable;
    logic        sample_valid;
    logic [7:0]  sample;
    logic [31:0] ctr_ctrl;
    logic [15:0] dev_ctrl;
    logic [7:0]  modulated;
    logic        mod_valid;
    logic        wrap;

    modport master (
        output enable, sample_valid, sample, ctr_ctrl, dev_ctrl,
        input  modulated, mod_valid, wrap
    );

    modport slave (
        input  enable, sample_valid, sample, ctr_ctrl, dev_ctrl,
        output modulated, mod_valid, wrap
    );
endinterface
`default_nettype wire

// File: rtl/fm_modulator.sv
`default_nettype none
// ============================================================================
//  Module      : fm_modulator
//  Description : Direct-digital FM modulator. A zero-order-held signed baseband
//                sample scales the deviation gain; the result offsets the
//                centre frequency word and drives a 32-bit phase accumulator
//                whose top byte addresses a 256-entry sine table.
//  Ports       : clk    - system clock, rising edge
//                reset  - asynchronous active-low reset
//                bus    - fm_modulator_if.slave (controls in, carrier out)
//  Revision    : 1.0  initial release
// ============================================================================
module fm_modulator #(
    parameter int PHASE_W = 32,
    parameter int LUT_AW  = 8
) (
    input  wire           clk,
    input  wire           reset,
    fm_modulator_if.slave bus
);

    // First quadrant of round(127*sin(2*pi*k/256)), k = 0..64 inclusive so
    // the peak is stored and both mirror points are exact.
    localparam logic [0:64][6:0] C_QUARTER_SINE = {
        7'd0,   7'd3,   7'd6,   7'd9,   7'd12,  7'd16,  7'd19,  7'd22,
        7'd25,  7'd28,  7'd31,  7'd34,  7'd37,  7'd40,  7'd43,  7'd46,
        7'd49,  7'd51,  7'd54,  7'd57,  7'd60,  7'd63,  7'd65,  7'd68,
        7'd71,  7'd73,  7'd76,  7'd78,  7'd81,  7'd83,  7'd85,  7'd88,
        7'd90,  7'd92,  7'd94,  7'd96,  7'd98,  7'd100, 7'd102, 7'd104,
        7'd106, 7'd107, 7'd109, 7'd111, 7'd112, 7'd113, 7'd115, 7'd116,
        7'd117, 7'd118, 7'd120, 7'd121, 7'd122, 7'd122, 7'd123, 7'd124,
        7'd125, 7'd125, 7'd126, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127,
        7'd127
    };

    logic [7:0]         hold_q, hold_d;
    logic [PHASE_W-1:0] off_q,  off_d;
    logic [PHASE_W-1:0] inc_q,  inc_d;
    logic [PHASE_W-1:0] acc_q,  acc_d;
    logic               wrap_q, wrap_d;
    logic [7:0]         mod_q,  mod_d;
    logic [3:0]         vld_q,  vld_d;

    logic [PHASE_W-1:0] w_hold_ext;
    logic [PHASE_W-1:0] w_dev_ext;
    logic [PHASE_W-1:0] w_off;
    logic [LUT_AW-1:0]  w_lut_idx;
    logic [6:0]         w_quarter_addr;
    logic [6:0]         w_mag;
    logic [7:0]         w_mag8;
    logic [7:0]         w_sine;

    // The low PHASE_W bits of a two's-complement product do not depend on
    // operand signedness, so a sign-extended sample times a zero-extended
    // gain yields the sign-extended 24-bit offset directly.
    assign w_hold_ext = {{(PHASE_W-8){hold_q[7]}}, hold_q};
    assign w_dev_ext  = {{(PHASE_W-16){1'b0}}, bus.dev_ctrl};
    assign w_off      = w_hold_ext * w_dev_ext;

    // Quarter-wave reconstruction: idx[6] mirrors within the half period,
    // idx[7] negates for the second half.
    assign w_lut_idx      = acc_q[PHASE_W-1 -: LUT_AW];
    assign w_quarter_addr = w_lut_idx[6] ? (7'd64 - {1'b0, w_lut_idx[5:0]})
                                         : {1'b0, w_lut_idx[5:0]};
    assign w_mag          = C_QUARTER_SINE[w_quarter_addr];
    assign w_mag8         = {1'b0, w_mag};
    assign w_sine         = w_lut_idx[7] ? (8'd0 - w_mag8) : w_mag8;

    always_comb begin
        hold_d = hold_q;
        off_d  = off_q;
        inc_d  = inc_q;
        acc_d  = acc_q;
        mod_d  = mod_q;
        vld_d  = vld_q;
        // Wrap is a strobe: a disabled edge clears it instead of holding it.
        wrap_d = 1'b0;
        if (bus.enable) begin
            if (bus.sample_valid) begin
                hold_d = bus.sample;
            end
            off_d           = w_off;
            inc_d           = bus.ctr_ctrl + off_q;
            {wrap_d, acc_d} = {1'b0, acc_q} + {1'b0, inc_q};
            mod_d           = w_sine;
            vld_d           = {vld_q[2:0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_q <= '0;
            off_q  <= '0;
            inc_q  <= '0;
            acc_q  <= '0;
            wrap_q <= 1'b0;
            mod_q  <= '0;
            vld_q  <= '0;
        end else begin
            hold_q <= hold_d;
            off_q  <= off_d;
            inc_q  <= inc_d;
            acc_q  <= acc_d;
            wrap_q <= wrap_d;
            mod_q  <= mod_d;
            vld_q  <= vld_d;
        end
    end

    assign bus.modulated = mod_q;
    assign bus.mod_valid = vld_q[3];
    assign bus.wrap      = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_fm_modulator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fm_modulator
//  Description : Self-checking bench for fm_modulator. A behavioural model
//                predicts every enabled/disabled edge; predictions are queued
//                before the edge and popped for comparison after it.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fm_modulator;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fm_modulator_if bus ();

    fm_modulator #(.PHASE_W(32), .LUT_AW(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [7:0] mod;
        logic       vld;
        logic       wrp;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // behavioural model state
    logic [7:0]  m_hold;
    logic [31:0] m_off, m_inc, m_acc;
    logic [7:0]  m_mod;
    logic        m_wrap;
    int          m_vcnt;

    function automatic int lut_ref(input logic [7:0] k);
        real r;
        r = 127.0 * $sin(2.0 * 3.141592653589793 * real'(k) / 256.0);
        if (r >= 0.0) return $rtoi(r + 0.5);
        else          return -$rtoi(0.5 - r);
    endfunction

    task automatic model_reset();
        m_hold = '0; m_off = '0; m_inc = '0; m_acc = '0;
        m_mod = '0; m_wrap = 1'b0; m_vcnt = 0;
        sb.delete();
    endtask

    // Predict the next edge from the current inputs, queue it, take the edge.
    task automatic advance();
        exp_t        e;
        logic [32:0] sum;
        int          prod;
        if (bus.enable) begin
            sum    = {1'b0, m_acc} + {1'b0, m_inc};
            m_mod  = 8'(lut_ref(m_acc[31:24]));
            m_acc  = sum[31:0];
            m_wrap = sum[32];
            m_inc  = bus.ctr_ctrl + m_off;
            prod   = int'($signed(m_hold)) * int'(bus.dev_ctrl);
            m_off  = prod;
            if (bus.sample_valid) m_hold = bus.sample;
            if (m_vcnt < 4) m_vcnt++;
        end else begin
            m_wrap = 1'b0;
        end
        e.mod = m_mod;
        e.vld = (m_vcnt >= 4);
        e.wrp = m_wrap;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic set_inputs(input logic en, input logic [31:0] ctr, input logic [15:0] dev);
        bus.enable       = en;
        bus.ctr_ctrl     = ctr;
        bus.dev_ctrl     = dev;
        bus.sample_valid = 1'b0;
        bus.sample       = 8'h00;
    endtask

    // Reset applied at posedge+1 and released at posedge+1 two edges later.
    task automatic pulse_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        set_inputs(1'b0, 32'h0, 16'h0);
        #2 reset = 1'b0;
        #1;
        checks++;
        if (bus.modulated !== 8'h00 || bus.mod_valid !== 1'b0 || bus.wrap !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: mod=%0h vld=%0b wrap=%0b expected 0/0/0",
                     bus.modulated, bus.mod_valid, bus.wrap);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.modulated !== 8'h00 || bus.mod_valid !== 1'b0 || bus.wrap !== 1'b0) begin
            errors++;
            $display("FAIL reset_held: mod=%0h vld=%0b wrap=%0b expected 0/0/0",
                     bus.modulated, bus.mod_valid, bus.wrap);
        end
        reset = 1'b1;
        model_reset();
    endtask

    task automatic test_carrier_step();
        exp_t e;
        int   wraps = 0;
        int   wrap_edge = -1;
        set_inputs(1'b1, 32'h0100_0000, 16'h0000);
        for (int n = 1; n <= 300; n++) begin
            advance();
            e = sb.pop_front();
            checks++;
            if ({bus.modulated, bus.mod_valid, bus.wrap} !== {e.mod, e.vld, e.wrp}) begin
                errors++;
                $display("FAIL carrier_step edge %0d: mod=%0d vld=%0b wrap=%0b expected %0d/%0b/%0b",
                         n, $signed(bus.modulated), bus.mod_valid, bus.wrap,
                         $signed(e.mod), e.vld, e.wrp);
            end
            if (bus.wrap === 1'b1) begin
                wraps++;
                if (wrap_edge < 0) wrap_edge = n;
            end
        end
        checks++;
        if (wraps != 1 || wrap_edge != 257) begin
            errors++;
            $display("FAIL carrier_wrap: count=%0d first_edge=%0d expected 1 at 257", wraps, wrap_edge);
        end
    endtask

    task automatic test_quarter_rate();
        exp_t e;
        int   wraps = 0;
        logic signed [7:0] pat [4];
        pat[0] = 8'sd0; pat[1] = -8'sd127; pat[2] = 8'sd0; pat[3] = 8'sd127;
        set_inputs(1'b1, 32'h4000_0000, 16'h0000);
        pulse_reset();
        for (int n = 1; n <= 20; n++) begin
            advance();
            e = sb.pop_front();
            checks++;
            if ({bus.modulated, bus.mod_valid, bus.wrap} !== {e.mod, e.vld, e.wrp}) begin
                errors++;
                $display("FAIL quarter_sb edge %0d: mod=%0d vld=%0b wrap=%0b expected %0d/%0b/%0b",
                         n, $signed(bus.modulated), bus.mod_valid, bus.wrap,
                         $signed(e.mod), e.vld, e.wrp);
            end
            if (n >= 4) begin
                checks++;
                if ($signed(bus.modulated) !== pat[(n-4)%4] || bus.mod_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL quarter_pattern edge %0d: mod=%0d vld=%0b expected %0d/1",
                             n, $signed(bus.modulated), bus.mod_valid, pat[(n-4)%4]);
                end
            end
            if (bus.wrap === 1'b1) wraps++;
        end
        checks++;
        if (wraps != 4) begin
            errors++;
            $display("FAIL quarter_wrap: count=%0d expected 4", wraps);
        end
    endtask

    task automatic test_neg_wrap();
        exp_t e;
        set_inputs(1'b1, 32'h0000_0010, 16'hFFFF);
        bus.sample       = 8'h80;
        bus.sample_valid = 1'b1;
        for (int n = 0; n <= 5; n++) begin
            advance();
            bus.sample_valid = 1'b0;
            e = sb.pop_front();
            checks++;
            if ({bus.modulated, bus.mod_valid, bus.wrap} !== {e.mod, e.vld, e.wrp}) begin
                errors++;
                $display("FAIL neg_sb edge E+%0d: mod=%0d wrap=%0b expected %0d/%0b",
                         n, $signed(bus.modulated), bus.wrap, $signed(e.mod), e.wrp);
            end
            if (n == 2) begin
                checks++;
                if (dut.inc_q !== 32'hFF80_0090) begin
                    errors++;
                    $display("FAIL neg_inc: inc=%08h expected ff800090", dut.inc_q);
                end
            end
            if (n >= 3) begin
                checks++;
                if (dut.acc_q !== m_acc) begin
                    errors++;
                    $display("FAIL neg_acc edge E+%0d: acc=%08h expected %08h", n, dut.acc_q, m_acc);
                end
            end
        end
    endtask

    task automatic test_latency();
        exp_t        e;
        logic [31:0] acc_exp [6];
        acc_exp[0] = 32'd0; acc_exp[1] = 32'd0; acc_exp[2] = 32'd0;
        acc_exp[3] = 32'd64; acc_exp[4] = 32'd128; acc_exp[5] = 32'd192;
        set_inputs(1'b1, 32'h0, 16'h0001);
        pulse_reset();
        repeat (3) begin
            advance();
            void'(sb.pop_front());
        end
        bus.sample       = 8'd64;
        bus.sample_valid = 1'b1;
        for (int n = 0; n <= 5; n++) begin
            advance();
            bus.sample_valid = 1'b0;
            e = sb.pop_front();
            checks++;
            if (dut.acc_q !== acc_exp[n]) begin
                errors++;
                $display("FAIL latency_acc edge E+%0d: acc=%0d expected %0d", n, dut.acc_q, acc_exp[n]);
            end
            checks++;
            if ({bus.modulated, bus.mod_valid} !== {e.mod, e.vld}) begin
                errors++;
                $display("FAIL latency_mod edge E+%0d: mod=%0d vld=%0b expected %0d/%0b",
                         n, $signed(bus.modulated), bus.mod_valid, $signed(e.mod), e.vld);
            end
        end
    endtask

    task automatic test_enable_hold();
        exp_t e;
        logic found = 1'b0;
        set_inputs(1'b1, 32'h4000_0000, 16'h0100);
        bus.sample       = 8'd5;
        bus.sample_valid = 1'b1;
        for (int n = 0; n < 8 && !found; n++) begin
            advance();
            bus.sample_valid = 1'b0;
            e = sb.pop_front();
            checks++;
            if ({bus.modulated, bus.mod_valid, bus.wrap} !== {e.mod, e.vld, e.wrp}) begin
                errors++;
                $display("FAIL hold_pre edge %0d: mod=%0d wrap=%0b expected %0d/%0b",
                         n, $signed(bus.modulated), bus.wrap, $signed(e.mod), e.wrp);
            end
            if (e.wrp) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL hold_find_wrap: no wrap within 8 edges, expected one");
        end
        bus.enable = 1'b0;
        for (int n = 0; n < 10; n++) begin
            bus.sample_valid = n[0];
            bus.sample       = 8'($urandom_range(0, 255));
            advance();
            e = sb.pop_front();
            checks++;
            if ({bus.modulated, bus.mod_valid, bus.wrap} !== {e.mod, e.vld, 1'b0} || dut.acc_q !== m_acc) begin
                errors++;
                $display("FAIL hold_frozen cycle %0d: mod=%0d vld=%0b wrap=%0b acc=%08h expected %0d/%0b/0/%08h",
                         n, $signed(bus.modulated), bus.mod_valid, bus.wrap, dut.acc_q,
                         $signed(e.mod), e.vld, m_acc);
            end
        end
        bus.enable = 1'b1;
        for (int n = 0; n < 20; n++) begin
            bus.sample_valid = 1'($urandom_range(0, 1));
            bus.sample       = 8'($urandom_range(0, 255));
            advance();
            e = sb.pop_front();
            checks++;
            if ({bus.modulated, bus.mod_valid, bus.wrap} !== {e.mod, e.vld, e.wrp}) begin
                errors++;
                $display("FAIL hold_resume edge %0d: mod=%0d wrap=%0b expected %0d/%0b",
                         n, $signed(bus.modulated), bus.wrap, $signed(e.mod), e.wrp);
            end
        end
        bus.sample_valid = 1'b0;
    endtask

    task automatic test_reset_midstream();
        exp_t e;
        set_inputs(1'b1, 32'h0500_0000, 16'h0000);
        repeat (12) begin
            advance();
            void'(sb.pop_front());
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (bus.modulated !== 8'h00 || bus.mod_valid !== 1'b0 || bus.wrap !== 1'b0) begin
            errors++;
            $display("FAIL midreset_async: mod=%0h vld=%0b wrap=%0b expected 0/0/0",
                     bus.modulated, bus.mod_valid, bus.wrap);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
        for (int n = 1; n <= 8; n++) begin
            advance();
            e = sb.pop_front();
            checks++;
            if (bus.mod_valid !== (n >= 4) ||
                {bus.modulated, bus.mod_valid, bus.wrap} !== {e.mod, e.vld, e.wrp}) begin
                errors++;
                $display("FAIL midreset_restart edge %0d: mod=%0d vld=%0b wrap=%0b expected %0d/%0b/%0b",
                         n, $signed(bus.modulated), bus.mod_valid, bus.wrap,
                         $signed(e.mod), (n >= 4), e.wrp);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_carrier_step();
        test_quarter_rate();
        test_neg_wrap();
        test_latency();
        test_enable_hold();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
